// File: rtl/datamemory_responder.sv
// datamemory_responder: handshaked word-wide data-memory target with programmable wait states.
// Optional byte-lane write strobes are enabled by defining DMEM_BYTE_STROBE_EN.
module datamemory_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  req_wstrb,
`endif
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_ready;
  logic                  r_valid;
  logic                  r_error;
  logic                  r_write;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_mem [2**ADDR_WIDTH];
  logic                  w_accept;
  logic                  w_err;
  logic                  w_store;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [3:0]            w_wstrb;
`ifdef DMEM_BYTE_STROBE_EN
  assign w_wstrb = req_wstrb;
`else
  assign w_wstrb = 4'hF;
`endif
  assign w_accept   = reset_n && r_ready && req_valid && r_state == IDLE;
  assign w_err      = (|r_addr[1:0]) || (|r_addr[31:ADDR_WIDTH+2]);
  assign w_idx      = r_addr[ADDR_WIDTH+1:2];
  assign w_store    = reset_n && r_state == RESP && r_write && !w_err;
  assign req_ready  = r_ready;
  assign resp_valid = r_valid;
  assign resp_rdata = r_rdata;
  assign resp_error = r_error;
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wstrb <= w_wstrb;
    end
  end
  // The access completes on the edge leaving RESP, so an abort in any busy state discards a store.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= !w_accept;
          if (w_accept) begin
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= WAIT_STATES == 0 ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt   <= r_cnt - 4'd1;
          r_state <= r_cnt == 4'd1 ? RESP : WAIT;
        end
        RESP: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b1;
          r_error <= w_err;
          r_rdata <= (r_write || w_err) ? 32'd0 : r_mem[w_idx];
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (w_store)
      for (int i = 0; i < 4; i++)
        if (r_wstrb[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_datamemory_responder.sv
// tb_datamemory_responder: table, random and directed checks of datamemory_responder.
module tb_datamemory_responder;
  localparam int WS = 2;
`ifdef DMEM_BYTE_STROBE_EN
  localparam bit STRB = 1'b1;
`else
  localparam bit STRB = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_a, rst_b, req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  req_wstrb;
`endif
  logic        a_ready, a_valid, a_error, b_ready, b_valid, b_error;
  logic [31:0] a_rdata, b_rdata;
  bit          sel;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_mem [int];
  wire         w_ready = sel ? b_ready : a_ready;
  wire         w_valid = sel ? b_valid : a_valid;
  wire         w_error = sel ? b_error : a_error;
  wire  [31:0] w_rdata = sel ? b_rdata : a_rdata;
  always #5 clk = ~clk;
  datamemory_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) u_a (
    .clk(clk), .reset_n(rst_a), .req_valid(req_valid), .req_ready(a_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_wstrb(req_wstrb),
`endif
    .resp_valid(a_valid), .resp_rdata(a_rdata), .resp_error(a_error));
  datamemory_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_b (
    .clk(clk), .reset_n(rst_b), .req_valid(req_valid), .req_ready(b_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_wstrb(req_wstrb),
`endif
    .resp_valid(b_valid), .resp_rdata(b_rdata), .resp_error(b_error));
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_er;
  } vec_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Word-level reference: a byte-addressed sparse memory with range/alignment rules.
  task automatic model(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rd, output bit er);
    int          key = int'(a[11:2]) + (sel ? 4096 : 0);
    logic [3:0]  s = STRB ? st : 4'hF;
    logic [31:0] w;
    er = (a[1:0] != 2'd0) || (a[31:12] != 20'd0);
    rd = 32'd0;
    if (!er) begin
      if (wr) begin
        w = m_mem.exists(key) ? m_mem[key] : 32'd0;
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = wd[8*b +: 8];
        m_mem[key] = w;
      end else rd = m_mem.exists(key) ? m_mem[key] : 32'hxxxxxxxx;
    end
  endtask
  task automatic xact(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output bit er);
    bit ok = 1'b0;
    int lat = -1;
    req_write = wr; req_addr = a; req_wdata = wd; req_valid = 1'b1;
`ifdef DMEM_BYTE_STROBE_EN
    req_wstrb = st;
`endif
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (w_ready) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom;
    rd = 32'hxxxxxxxx; er = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (w_valid) begin lat = k - 1; rd = w_rdata; er = w_error; break; end
    end
    chk("latency", 32'(lat), sel ? 32'd1 : 32'(WS + 1));
    @(negedge clk);
    chk("single_pulse", 32'(w_valid), 32'd0);
  endtask
  initial begin
    vec_t        tbl [12];
    logic [31:0] rd, mrd, a;
    bit          er, mer;
    int          rsp, accb, lat;
    bit          seen;
    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0012, 32'h0,        32'h0,        1'b1};
    tbl[3]  = '{1'b1, 32'h0000_1000, 32'hBAD0BAD0, 32'h0,        1'b1};
    tbl[4]  = '{1'b0, 32'h0000_0000, 32'h0,        32'hA5A5A5A5, 1'b0};
    tbl[5]  = '{1'b1, 32'h0000_0020, 32'h0000_0001, 32'h0,       1'b0};
    tbl[6]  = '{1'b0, 32'h0000_0020, 32'h0,        32'h0000_0001, 1'b0};
    tbl[7]  = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0005, 32'h0,       1'b1};
    tbl[8]  = '{1'b1, 32'h0000_0FFC, 32'hCAFEF00D, 32'h0,        1'b0};
    tbl[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,        32'hCAFEF00D, 1'b0};
    tbl[10] = '{1'b0, 32'h0000_0003, 32'h0,        32'h0,        1'b1};
    tbl[11] = '{1'b0, 32'h0000_0000, 32'h0,        32'hA5A5A5A5, 1'b0};
    sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
    req_wstrb = 4'hF;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(a_ready), 32'd0);
    chk("reset_valid", 32'(a_valid), 32'd0);
    chk("reset_rdata", a_rdata, 32'd0);
    chk("reset_error", 32'(a_error), 32'd0);
    rst_a = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(a_ready), 32'd1);
    model(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, mrd, mer);
    xact(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, rd, er);
    chk("init_store_err", 32'(er), 32'd0);
    // reset held with a pending store request must leave memory untouched
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF; rst_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold_reset_ready", 32'(a_ready), 32'd0);
      chk("hold_reset_valid", 32'(a_valid), 32'd0);
    end
    req_valid = 1'b0; rst_a = 1'b1;
    #1 chk("release_ready_low", 32'(a_ready), 32'd0);
    @(negedge clk);
    chk("release_ready_high", 32'(a_ready), 32'd1);
    foreach (tbl[i]) begin
      model(tbl[i].wr, tbl[i].addr, tbl[i].wd, 4'hF, mrd, mer);
      xact(tbl[i].wr, tbl[i].addr, tbl[i].wd, 4'hF, rd, er);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_error", i), 32'(er), 32'(tbl[i].exp_er));
    end
    for (int i = 0; i < 16; i++) begin
      a = 32'(i * 4);
      model(1'b1, a, $urandom, 4'hF, mrd, mer);
      xact(1'b1, a, m_mem[i], 4'hF, rd, er);
      chk("preinit_error", 32'(er), 32'd0);
    end
    for (int n = 0; n < 60; n++) begin
      int          r = $urandom_range(0, 7);
      bit          wr = 1'($urandom_range(0, 1));
      logic [31:0] wd = $urandom;
      logic [3:0]  st = 4'($urandom);
      a = 32'($urandom_range(0, 15) * 4);
      if (r == 6) a = a | 32'($urandom_range(1, 3));
      if (r == 7) a = a | (32'h1000 << $urandom_range(0, 19));
      model(wr, a, wd, st, mrd, mer);
      xact(wr, a, wd, st, rd, er);
      chk($sformatf("rand%0d_rdata@%h", n, a), rd, mrd);
      chk($sformatf("rand%0d_error@%h", n, a), 32'(er), 32'(mer));
    end
    // two queued requests: B must wait for the first idle cycle after A's response
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h77;
`ifdef DMEM_BYTE_STROBE_EN
    req_wstrb = 4'hF;
`endif
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (w_ready) begin seen = 1'b1; break; end
    end
    chk("stall_accept_a", 32'(seen), 32'd1);
    model(1'b1, 32'h30, 32'h77, 4'hF, mrd, mer);
    @(posedge clk);
    #1 req_write = 1'b0;
    rsp = -1; accb = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (w_valid) rsp = k - 1;
      if (w_ready) begin accb = k; break; end
    end
    chk("stall_resp_a_edge", 32'(rsp), 32'(WS + 1));
    chk("stall_accept_b_edge", 32'(accb), 32'(WS + 2));
    @(posedge clk);
    #1 req_valid = 1'b0; req_addr = 32'h44;
    lat = -1; rd = 32'd0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (w_valid) begin lat = k - 1; rd = w_rdata; break; end
    end
    chk("stall_b_latency", 32'(lat), 32'(WS + 1));
    chk("stall_b_rdata", rd, 32'h77);
    // abort a store to 0x20 during its wait states
    model(1'b1, 32'h20, 32'h1, 4'hF, mrd, mer);
    xact(1'b1, 32'h20, 32'h1, 4'hF, rd, er);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h99;
    for (int i = 0; i < 50 && !w_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_a = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= w_valid; end
    rst_a = 1'b1;
    repeat (6) begin @(negedge clk); seen |= w_valid; end
    chk("abort_no_resp", 32'(seen), 32'd0);
    model(1'b0, 32'h20, 32'h0, 4'hF, mrd, mer);
    xact(1'b0, 32'h20, 32'h0, 4'hF, rd, er);
    chk("abort_readback", rd, 32'h1);
    chk("abort_readback_model", rd, mrd);
    // zero-wait-state instance
    rst_a = 1'b0; sel = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);
    model(1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, mrd, mer);
    xact(1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, rd, er);
    chk("ws0_store_error", 32'(er), 32'd0);
    model(1'b1, 32'h40, 32'h1122_3344, 4'b0101, mrd, mer);
    xact(1'b1, 32'h40, 32'h1122_3344, 4'b0101, rd, er);
    chk("ws0_strobe_store_rdata", rd, 32'd0);
    model(1'b0, 32'h40, 32'h0, 4'h0, mrd, mer);
    xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er);
    chk("ws0_strobe_readback", rd, STRB ? 32'hFF22_FF44 : 32'h1122_3344);
    chk("ws0_readback_model", rd, mrd);
    xact(1'b0, 32'h42, 32'h0, 4'hF, rd, er);
    chk("ws0_misaligned_error", 32'(er), 32'd1);
    chk("ws0_misaligned_rdata", rd, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
